mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- 8-requester round-robin arbiter that owns the select lines of a mux8 instance and shares the 1-bit datapath between requesters.
- A granted requester holds the mux until it drops its request.
- Grant and select are registered; data routing through the embedded mux8 is combinational.
- Sits between eight bit-serial sources and a single downstream consumer.

Parameters:
- RESET_PTR, 3'd0, index with top priority after reset.
- TIMEOUT_CYCLES, 8'd16, maximum consecutive GRANT cycles before forced release; used only with ARB_TIMEOUT_EN; legal 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request per source; held high for the whole transfer.
- data_in  input  8  one data bit per source.
- gnt  output  8  one-hot registered grant; all zeros when idle.
- select  output  3  registered binary index of the owner; drives mux8 select.
- valid  output  1  registered; high while any grant is active.
- data_out  output  1  mux8(data_in, select) AND valid.
- timeout  output  1  one-cycle pulse on forced release; tied 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gnt=0, select=0, valid=0, timeout=0.
  - ptr=RESET_PTR, hold counter=0.
  - Reset asserted mid-grant drops gnt immediately (not clock-aligned).
- FSM states: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first i scanning ptr, ptr+1, …, ptr+7 (mod 8) with req[i]=1.
  - Next edge: gnt=1<<i, select=i, valid=1, ptr=(i+1) mod 8 (7 wraps to 0), state=GRANT.
  - Latency: req rises at edge N, gnt is high after edge N+1.
- GRANT:
  - While req[select]=1, hold gnt, select and valid; ignore all other requests.
  - When req[select]=0 at an edge: gnt=0, valid=0, state=IDLE. select keeps its last value.
  - This gives one mandatory dead cycle between owners for bus turnaround.
  - Minimum spacing between consecutive grants is 2 cycles.
- Requests rising in the same cycle are resolved purely by the rotating ptr.
- A requester that drops req before being granted is simply not chosen; no memory of past requests.
- gnt is always one-hot or zero; select==index of the set gnt bit whenever valid=1.
- data_out is 0 whenever valid=0, regardless of data_in.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entering GRANT and increments each GRANT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 while req[select] is still 1, the next edge forces gnt=0, valid=0, state=IDLE and pulses timeout=1 for one cycle.
  - ptr has already moved past the owner, so it re-competes at the lowest priority.
  - A voluntary release and the timeout on the same edge count as a voluntary release: timeout=0.
- Undefined: no counter logic is built, timeout is constant 0, and grants are unbounded.

Decomposition:
- Shared header/package: state encodings (ARB_IDLE=1'b0, ARB_GRANT=1'b1), requester count 8, index width 3.
- Sub-module rr_pick8 (combinational):
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0]; rotate, priority-encode, unrotate.
- Existing mux8 is instantiated unchanged for data routing.

Test Plan:
- Reset then req=8'h01 -> after 1 edge gnt=8'h01, select=0, valid=1; data_in[0] toggling appears on data_out.
- req=8'hFF held, each owner drops req for one cycle after 3 GRANT cycles -> grant order 0,1,2,…,7,0 with one idle cycle between owners.
- ptr=7 (last grant to 6), req=8'h81 -> gnt=8'h80, then after release gnt=8'h01 (wrap-around).
- Owner 3 granted, req[5] rises mid-grant -> gnt stays 8'h08 until req[3] falls; gnt=8'h20 two edges later.
- rst pulsed while gnt=8'h10 -> gnt, valid, data_out go to 0 without a clock edge; next arbitration starts from RESET_PTR.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, req=8'h05 held -> gnt=8'h01 for 4 cycles, timeout pulse, idle cycle, gnt=8'h04 for 4 cycles, timeout pulse, gnt=8'h01 again.

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// mux8_rr_arbiter_pkg: shared widths and FSM encoding for the round-robin mux8 arbiter.
package mux8_rr_arbiter_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_GRANT = 1'b1} arb_state_e;
endpackage

// File: rtl/mux8.sv
// mux8: 8:1 single-bit multiplexer.
module mux8 (
    input  logic [7:0] d,
    input  logic [2:0] sel,
    output logic       y
);
    assign y = d[sel];
endmodule

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// rr_pick8: first set request at or after ptr (rotate, priority-encode, unrotate).
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    always_comb begin
        rot = N_REQ'({req, req} >> ptr);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
    end
    assign any = |req;
    assign idx = ptr + off;
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: 8-way round-robin owner of a mux8 select; holds until the owner drops req.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT_CYCLES grant cycles.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter logic [IDX_W-1:0] RESET_PTR      = 3'd0,
    parameter logic [7:0]       TIMEOUT_CYCLES = 8'd16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data_in,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] select,
    output logic             valid,
    output logic             data_out,
    output logic             timeout
);
    if (TIMEOUT_CYCLES == 8'd0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be 1..255");
    end
    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] sel_q, sel_d, ptr_q, ptr_d, pick_idx;
    logic             valid_q, valid_d, pick_any, mux_y;
`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
`endif
    rr_pick8 u_pick (.req(req), .ptr(ptr_q), .any(pick_any), .idx(pick_idx));
    mux8 u_mux (.d(data_in), .sel(sel_q), .y(mux_y));
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        if (state_q == ARB_IDLE) begin
            if (pick_any) begin
                state_d = ARB_GRANT;
                gnt_d   = N_REQ'(1) << pick_idx;
                sel_d   = pick_idx;
                valid_d = 1'b1;
                ptr_d   = pick_idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
        end else if (!req[sel_q]) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        // ptr already points past the owner, so a forced release sends it to the back
        else if (cnt_q == TIMEOUT_CYCLES - 8'd1) begin
            state_d   = ARB_IDLE;
            gnt_d     = '0;
            valid_d   = 1'b0;
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= RESET_PTR;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end
`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif
    assign gnt      = gnt_q;
    assign select   = sel_q;
    assign valid    = valid_q;
    assign data_out = mux_y & valid_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed test-plan checks plus randomized traffic against a behavioural model.
module tb_mux8_rr_arbiter;
    localparam logic [2:0] RP = 3'd0;
    localparam int         TO = 4;
    logic       clk, rst, valid, data_out, timeout;
    logic [7:0] req, data_in, gnt;
    logic [2:0] select;
    int n_checks = 0, n_fail = 0;
    int m_owner = -1, m_sel = 0, m_ptr = 0, m_held = 0;
    bit m_to = 0;

    mux8_rr_arbiter #(.RESET_PTR(RP), .TIMEOUT_CYCLES(8'(TO))) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt),
        .select(select), .valid(valid), .data_out(data_out), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner index or -1 when idle; scan from ptr for the first requester.
    task automatic model_step();
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1; m_sel = 0; m_ptr = int'(RP); m_held = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 8; k++) begin
                int i = (m_ptr + k) % 8;
                if (req[i] && m_owner < 0) begin
                    m_owner = i; m_sel = i; m_ptr = (i + 1) % 8; m_held = 1;
                end
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_held == TO) begin
            m_owner = -1; m_to = 1'b1;
        end
`endif
        else m_held++;
    endtask

    always begin
        @(posedge clk);
        model_step();
        #1;
        check("model_gnt", gnt, (m_owner < 0) ? 8'h00 : (8'h01 << m_owner));
        check("model_select", {5'd0, select}, 8'(m_sel));
        check("model_valid", {7'd0, valid}, {7'd0, m_owner >= 0});
        check("model_data_out", {7'd0, data_out}, {7'd0, (m_owner >= 0) && data_in[m_sel]});
        check("model_timeout", {7'd0, timeout}, {7'd0, m_to});
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; data_in = '0;
        repeat (3) tick();
        check("rst_gnt", gnt, 8'h00);
        check("rst_select", {5'd0, select}, 8'h00);
        check("rst_valid", {7'd0, valid}, 8'h00);
        check("rst_timeout", {7'd0, timeout}, 8'h00);
        rst = 1'b0;
        req = 8'h01;
        tick();
        check("first_gnt", gnt, 8'h01);
        check("first_valid", {7'd0, valid}, 8'h01);
        data_in = 8'h01; #1;
        check("route_hi", {7'd0, data_out}, 8'h01);
        data_in = 8'hFE; #1;
        check("route_lo", {7'd0, data_out}, 8'h00);
        req = 8'h00;
        tick();
        check("release", gnt, 8'h00);
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("rr_order", gnt, 8'h01 << (k % 8));
            tick(); tick();
            req[k % 8] = 1'b0;
            tick();
            check("rr_dead", gnt, 8'h00);
            req = 8'hFF;
        end
        req = 8'h40;
        tick(); check("wrap_pre", gnt, 8'h40);
        req = 8'h00;
        tick(); check("wrap_idle", gnt, 8'h00);
        req = 8'h81;
        tick(); check("wrap_7", gnt, 8'h80);
        req = 8'h01;
        tick(); check("wrap_dead", gnt, 8'h00);
        tick(); check("wrap_0", gnt, 8'h01);
        req = 8'h00;
        tick();
        req = 8'h08;
        tick(); check("hold_3", gnt, 8'h08);
        req = 8'h28;
        tick(); check("hold_keep1", gnt, 8'h08);
        tick(); check("hold_keep2", gnt, 8'h08);
        req = 8'h20;
        tick(); check("hold_dead", gnt, 8'h00);
        tick(); check("hold_5", gnt, 8'h20);
        req = 8'h00;
        tick();
        req = 8'h10;
        tick(); check("async_pre", gnt, 8'h10);
        data_in = 8'h10; #1;
        check("async_data_pre", {7'd0, data_out}, 8'h01);
        #2 rst = 1'b1; #1;
        check("async_gnt", gnt, 8'h00);
        check("async_valid", {7'd0, valid}, 8'h00);
        check("async_data", {7'd0, data_out}, 8'h00);
        tick();
        rst = 1'b0; req = 8'hFF;
        tick(); check("async_restart", gnt, 8'h01 << RP);
        req = 8'h00;
        tick();
`ifdef ARB_TIMEOUT_EN
        do_reset();
        req = 8'h05;
        for (int r = 0; r < 4; r++) begin tick(); check("to_own0", gnt, 8'h01); end
        tick(); check("to_idle0", gnt, 8'h00); check("to_pulse0", {7'd0, timeout}, 8'h01);
        for (int r = 0; r < 4; r++) begin tick(); check("to_own2", gnt, 8'h04); end
        tick(); check("to_pulse2", {7'd0, timeout}, 8'h01);
        tick(); check("to_back0", gnt, 8'h01);
        req = 8'h00;
        tick();
`endif
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int b = 0; b < 8; b++) if ($urandom_range(5) == 0) req[b] = ~req[b];
            data_in = 8'($urandom);
            if ($urandom_range(400) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        req = '0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
